beta_if_stage: RTL and testbench
================================

Name: beta_if_stage

Overview:
Instruction fetch stage and the transmitting end of the decode stage's instruction interface. Holds the PC, runs a single-outstanding request/grant/rvalid transaction on instruction memory, and presents each fetched word to decode with a one-cycle new-instruction pulse. It fetches the next word only after downstream signals completion, and accepts a redirect at that point.

Parameters:
DataWidth, 32, width of PC, address and instruction lines (only 32 supported)
BootAddr, 32'h0000_0000, PC value after reset (word aligned)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
if_fetch_en_i  in  1  fetch enable
imem_req_o  out  1  instruction memory request
imem_addr_o  out  DataWidth  request address (current PC)
imem_gnt_i  in  1  request accepted
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  DataWidth  read data
imem_err_i  in  1  bus error with rvalid (used only with feature)
if_instr_o  out  DataWidth  instruction to decode
if_new_instr_o  out  1  one-cycle pulse: new if_instr_o valid
if_pc_o  out  DataWidth  PC of if_instr_o
if_next_pc_o  out  DataWidth  if_pc_o + 4
if_advance_i  in  1  pulse: downstream finished current instruction
if_redirect_i  in  1  with advance: take redirect target
if_redirect_pc_i  in  DataWidth  redirect target
if_stage_busy_o  out  1  imem transaction in flight
if_fetch_err_o  out  1  sticky fetch error (feature)

Behaviour:
- Reset values: state IDLE, PC=BootAddr, imem_req_o=0, imem_addr_o=BootAddr, if_instr_o=32'h0000_0013 (NOP), if_new_instr_o=0, if_pc_o=BootAddr, if_next_pc_o=BootAddr+4, if_stage_busy_o=0, if_fetch_err_o=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: if if_fetch_en_i, go to REQ next cycle; else stay. rvalid/gnt ignored.
- REQ: imem_req_o=1, imem_addr_o=PC and stable until gnt. On gnt, go to WAIT. rvalid in REQ is ignored.
- WAIT: on imem_rvalid_i, register imem_rdata_i into if_instr_o, set if_pc_o=PC, and go to HOLD. Earliest rvalid is the cycle after gnt.
- HOLD: if_new_instr_o=1 only in the first HOLD cycle. Wait for if_advance_i, which may coincide with the pulse cycle.
- On advance: PC <= if_redirect_i ? {if_redirect_pc_i[31:2],2'b00} : PC+4. Then go to REQ if if_fetch_en_i, else IDLE.
- Minimum loop: advance to next new_instr pulse is 3 cycles with gnt and rvalid each arriving in the first cycle allowed.
- if_advance_i and if_redirect_i outside HOLD are ignored.
- if_stage_busy_o = (state==REQ) | (state==WAIT).
- Dropping if_fetch_en_i mid-transaction: the transaction completes and delivers normally; no further request is made.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Asynchronous reset mid-transaction: immediate return to reset values. A late rvalid arriving after release lands in IDLE or REQ and is dropped.

Optional Feature:
Macro BETA_IF_FETCH_ERR_EN.
- Defined: imem_err_i is sampled with imem_rvalid_i. On error, if_instr_o=32'h0000_0013 instead of rdata, the pulse still fires, and if_fetch_err_o sets sticky until reset.
- Undefined: imem_err_i is ignored and if_fetch_err_o is tied to 0.
- Ports exist in both builds.

Test Plan:
- Reset release, en=1, gnt the cycle after req, rvalid next cycle with rdata=32'h0050_0093 -> imem_addr_o=0, if_instr_o=32'h0050_0093, if_pc_o=0, if_next_pc_o=4, one-cycle pulse.
- Advance without redirect, then hold gnt low 3 cycles -> req and addr=4 held stable all 3 cycles, busy=1, no pulse until rvalid.
- Advance with redirect=1, target=32'h0000_0102 -> next imem_addr_o=32'h0000_0100.
- PC=32'hFFFF_FFFC, advance -> next fetch at 32'h0000_0000.
- Assert rst_i in WAIT, release, then rvalid arrives -> rvalid dropped, no pulse, first new request at BootAddr.
- With BETA_IF_FETCH_ERR_EN: rvalid with imem_err_i=1, rdata=32'hDEAD_BEEF -> if_instr_o=32'h0000_0013, if_fetch_err_o=1 and still 1 after the next good fetch. Without the macro: if_instr_o=32'hDEAD_BEEF, if_fetch_err_o=0.

Source files
------------

// File: rtl/beta_if_stage.sv
// beta_if_stage: instruction fetch stage, single-outstanding imem transaction feeding decode.
// Define BETA_IF_FETCH_ERR_EN to turn imem_err_i into a NOP substitution plus a sticky if_fetch_err_o.
module beta_if_stage #(
  parameter int DataWidth = 32,
  parameter logic [DataWidth-1:0] BootAddr = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_fetch_en_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  input  logic                 imem_err_i,
  output logic [DataWidth-1:0] if_instr_o,
  output logic                 if_new_instr_o,
  output logic [DataWidth-1:0] if_pc_o,
  output logic [DataWidth-1:0] if_next_pc_o,
  input  logic                 if_advance_i,
  input  logic                 if_redirect_i,
  input  logic [DataWidth-1:0] if_redirect_pc_i,
  output logic                 if_stage_busy_o,
  output logic                 if_fetch_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);
  state_t state;
  logic [DataWidth-1:0] pc, next_pc;
  logic fetch_err, err_q, unused_in;
`ifdef BETA_IF_FETCH_ERR_EN
  assign fetch_err = imem_err_i;
`else
  assign fetch_err = 1'b0;
`endif
  // Redirect targets are forced word aligned, so the low bits are never consumed.
  assign unused_in = ^{imem_err_i, if_redirect_pc_i[1:0]};
  assign next_pc = if_redirect_i ? {if_redirect_pc_i[DataWidth-1:2], 2'b00} : pc + DataWidth'(4);
  assign imem_req_o = state == REQ;
  assign imem_addr_o = pc;
  assign if_stage_busy_o = (state == REQ) | (state == WAIT);
  assign if_next_pc_o = if_pc_o + DataWidth'(4);
  assign if_fetch_err_o = err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc <= BootAddr;
      if_instr_o <= Nop;
      if_pc_o <= BootAddr;
      if_new_instr_o <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if_new_instr_o <= 1'b0;
      case (state)
        IDLE: if (if_fetch_en_i) state <= REQ;
        REQ: if (imem_gnt_i) state <= WAIT;
        WAIT: if (imem_rvalid_i) begin
          state <= HOLD;
          if_instr_o <= fetch_err ? Nop : imem_rdata_i;
          if_pc_o <= pc;
          if_new_instr_o <= 1'b1;
          err_q <= err_q | fetch_err;
        end
        HOLD: if (if_advance_i) begin
          pc <= next_pc;
          state <= if_fetch_en_i ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_beta_if_stage.sv
// tb_beta_if_stage: randomized fetch-loop bench against a transaction-level PC/instruction model.
module tb_beta_if_stage;
  logic clk_i = 1'b0;
  logic rst_i, if_fetch_en_i, imem_gnt_i, imem_rvalid_i, imem_err_i, if_advance_i, if_redirect_i;
  logic [31:0] imem_rdata_i, if_redirect_pc_i, imem_addr_o, if_instr_o, if_pc_o, if_next_pc_o;
  logic imem_req_o, if_new_instr_o, if_stage_busy_o, if_fetch_err_o;
  int total = 0, bad = 0;
  logic [31:0] exp_pc;
  logic exp_err;
`ifdef BETA_IF_FETCH_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  beta_if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_fetch_en_i(if_fetch_en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .if_instr_o(if_instr_o), .if_new_instr_o(if_new_instr_o), .if_pc_o(if_pc_o),
    .if_next_pc_o(if_next_pc_o), .if_advance_i(if_advance_i), .if_redirect_i(if_redirect_i),
    .if_redirect_pc_i(if_redirect_pc_i), .if_stage_busy_o(if_stage_busy_o),
    .if_fetch_err_o(if_fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic noise(input bit on);
    if_advance_i = on && 1'($urandom_range(0, 1));
    if_redirect_i = on && 1'($urandom_range(0, 1));
    if_redirect_pc_i = $urandom;
  endtask

  // Entered with the DUT expected in REQ; leaves it in the first HOLD cycle.
  task automatic do_fetch(input int gd, input int rd, input logic [31:0] data, input logic er,
                          input bit drop, input bit nz);
    logic [31:0] exp_instr;
    for (int i = 0; i <= gd; i++) begin
      total++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc || if_stage_busy_o !== 1'b1 || if_new_instr_o !== 1'b0) begin
        bad++;
        $display("FAIL req_phase req=%b addr=%h busy=%b pulse=%b expected req=1 addr=%h busy=1 pulse=0",
                 imem_req_o, imem_addr_o, if_stage_busy_o, if_new_instr_o, exp_pc);
      end
      imem_gnt_i = (i == gd);
      imem_rvalid_i = nz && 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      noise(nz);
      step();
    end
    imem_gnt_i = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      total++;
      if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1 || if_new_instr_o !== 1'b0) begin
        bad++;
        $display("FAIL wait_phase req=%b busy=%b pulse=%b expected 0/1/0", imem_req_o, if_stage_busy_o, if_new_instr_o);
      end
      if (drop) if_fetch_en_i = 1'b0;
      imem_rvalid_i = (i == rd);
      imem_rdata_i = (i == rd) ? data : $urandom;
      imem_err_i = (i == rd) ? er : 1'($urandom_range(0, 1));
      noise(nz);
      step();
    end
    imem_rvalid_i = 1'b0;
    imem_err_i = 1'b0;
    noise(1'b0);
    if (FE && er) exp_err = 1'b1;
    exp_instr = (FE && er) ? NOP : data;
    total++;
    if (if_new_instr_o !== 1'b1 || if_stage_busy_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL pulse pulse=%b busy=%b req=%b expected 1/0/0", if_new_instr_o, if_stage_busy_o, imem_req_o);
    end
    total++;
    if (if_instr_o !== exp_instr) begin
      bad++;
      $display("FAIL instr got=%h expected=%h", if_instr_o, exp_instr);
    end
    total++;
    if (if_pc_o !== exp_pc || if_next_pc_o !== exp_pc + 32'd4) begin
      bad++;
      $display("FAIL pc got pc=%h next=%h expected pc=%h next=%h", if_pc_o, if_next_pc_o, exp_pc, exp_pc + 32'd4);
    end
    total++;
    if (if_fetch_err_o !== exp_err) begin
      bad++;
      $display("FAIL fetch_err got=%b expected=%b", if_fetch_err_o, exp_err);
    end
  endtask

  task automatic do_advance(input int h, input logic rdr, input logic [31:0] tgt);
    for (int i = 0; i < h; i++) begin
      step();
      total++;
      if (if_new_instr_o !== 1'b0 || imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b0) begin
        bad++;
        $display("FAIL hold pulse=%b req=%b busy=%b expected 0/0/0", if_new_instr_o, imem_req_o, if_stage_busy_o);
      end
    end
    if_advance_i = 1'b1;
    if_redirect_i = rdr;
    if_redirect_pc_i = tgt;
    step();
    if_advance_i = 1'b0;
    if_redirect_i = 1'b0;
    exp_pc = rdr ? (tgt & ~32'd3) : exp_pc + 32'd4;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      total++;
      if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b0 || if_new_instr_o !== 1'b0 || imem_addr_o !== exp_pc) begin
        bad++;
        $display("FAIL idle req=%b busy=%b pulse=%b addr=%h expected 0/0/0 addr=%h",
                 imem_req_o, if_stage_busy_o, if_new_instr_o, imem_addr_o, exp_pc);
      end
      imem_gnt_i = 1'($urandom_range(0, 1));
      imem_rvalid_i = 1'($urandom_range(0, 1));
      noise(1'b1);
      step();
    end
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    noise(1'b0);
    if_fetch_en_i = 1'b1;
    step();
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b0 || if_new_instr_o !== 1'b0 || if_fetch_err_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_ctrl req=%b busy=%b pulse=%b err=%b expected all 0", tag,
               imem_req_o, if_stage_busy_o, if_new_instr_o, if_fetch_err_o);
    end
    total++;
    if (imem_addr_o !== 32'h0 || if_pc_o !== 32'h0 || if_next_pc_o !== 32'h4) begin
      bad++;
      $display("FAIL %s_pc addr=%h pc=%h next=%h expected 0/0/4", tag, imem_addr_o, if_pc_o, if_next_pc_o);
    end
    total++;
    if (if_instr_o !== NOP) begin
      bad++;
      $display("FAIL %s_instr got=%h expected=%h", tag, if_instr_o, NOP);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; if_fetch_en_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_err_i = 1'b0;
    imem_rdata_i = '0; noise(1'b0);
    step();
    step();
    check_reset_values("reset");
    exp_pc = 32'h0;
    exp_err = 1'b0;
    rst_i = 1'b0;
    if_fetch_en_i = 1'b1;
    step();
  endtask

  task automatic test_first_fetch();
    do_fetch(0, 0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    do_advance(1, 1'b0, 32'h0);
  endtask

  task automatic test_stall();
    do_fetch(3, 0, $urandom, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b1, 32'h0000_0102);
  endtask

  task automatic test_redirect();
    total++;
    if (imem_addr_o !== 32'h0000_0100) begin
      bad++;
      $display("FAIL redirect_addr got=%h expected=00000100", imem_addr_o);
    end
    do_fetch(0, 1, $urandom, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b1, 32'hFFFF_FFFE);
  endtask

  task automatic test_wrap();
    do_fetch(1, 0, $urandom, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b0, 32'h0);
    total++;
    if (imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_addr got=%h expected=00000000", imem_addr_o);
    end
    do_fetch(1, 1, $urandom, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b0, 32'h0);
  endtask

  task automatic test_fetch_err();
    do_fetch(0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    do_advance(0, 1'b0, 32'h0);
    do_fetch(0, 0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b0, 32'h0);
  endtask

  task automatic test_en_drop();
    do_fetch(1, 2, $urandom, 1'b0, 1'b1, 1'b0);
    do_advance(0, 1'b0, 32'h0);
    idle_check(3);
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    #3 rst_i = 1'b1;
    #1 check_reset_values("async_reset");
    exp_pc = 32'h0;
    exp_err = 1'b0;
    step();
    rst_i = 1'b0;
    if_fetch_en_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = $urandom;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (if_new_instr_o !== 1'b0 || if_instr_o !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
        bad++;
        $display("FAIL late_rvalid pulse=%b instr=%h req=%b addr=%h expected 0/%h/1/0",
                 if_new_instr_o, if_instr_o, imem_req_o, imem_addr_o, NOP);
      end
    end
    imem_rvalid_i = 1'b0;
    do_fetch(0, 0, $urandom, 1'b0, 1'b0, 1'b0);
    do_advance(0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) == 0, 1'b1);
      do_advance($urandom_range(0, 2), $urandom_range(0, 2) == 0, $urandom);
      if (!if_fetch_en_i) idle_check($urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_fetch_err();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
